wb_arbiter: RTL and testbench

- Pipelined Wishbone B4 arbiter: NUM_MASTERS masters share one downstream Wishbone port.
- The downstream port normally feeds the platform wishbone interconnect.
- Round-robin grant; the grant is held for the whole bus cycle (cyc, or lock).
- Tracks outstanding requests and caps them so the upstream path never overflows.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wishbone_if.sv | 29 ++
 rtl/wb_arbiter_rr_arbiter.sv | 30 +++
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Optional watchdog macro: WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int outst_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone B4 bundle.
// MASTER drives the request, SLAVE drives the response.
interface wishbone_if;
  import wb_arb_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [SW-1:0] sel;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;
  logic          rty;
  logic          stall;

  modport MASTER (
    output cyc, stb, we, lock, addr, sel, wdata,
    input  rdata, ack, err, rty, stall
  );

  modport SLAVE (
    input  cyc, stb, we, lock, addr, sel, wdata,
    output rdata, ack, err, rty, stall
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester
// strictly after the pointer, wrapping around.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_c;

  // Scan far-to-near so the nearest requester wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_c   = '0;
    for (int k = N; k >= 1; k--) begin
      w_c = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_c]) begin
        o_gnt      = '0;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Pipelined Wishbone B4 round-robin arbiter with outstanding cap.
// Optional watchdog macro: WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  wishbone_if.SLAVE              wb_m_if [NUM_MASTERS],
  wishbone_if.MASTER             wb_s_if,
  output logic [NUM_MASTERS-1:0] grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int OW = outst_width(MAX_OUTSTANDING);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  if (NUM_MASTERS < 2) begin : g_bad_nm
    $error("NUM_MASTERS must be >= 2");
  end
  if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_lim
    $error("MAX_OUTSTANDING and TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t r_state, w_state_nx;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nx, w_win;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic [IW-1:0] r_ptr, w_ptr_nx, w_win_idx;
  logic [OW-1:0] r_outst, w_outst_nx;

  logic [NUM_MASTERS-1:0] w_m_cyc, w_m_stb;
  logic [NUM_MASTERS-1:0] w_m_we, w_m_lock;
  logic [AW-1:0] w_m_addr  [NUM_MASTERS];
  logic [SW-1:0] w_m_sel   [NUM_MASTERS];
  logic [DW-1:0] w_m_wdata [NUM_MASTERS];

  logic w_gnt, w_full, w_resp, w_acc;
  logic w_stall_g, w_tmo;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    assign w_m_cyc[g]   = wb_m_if[g].cyc;
    assign w_m_stb[g]   = wb_m_if[g].stb;
    assign w_m_we[g]    = wb_m_if[g].we;
    assign w_m_lock[g]  = wb_m_if[g].lock;
    assign w_m_addr[g]  = wb_m_if[g].addr;
    assign w_m_sel[g]   = wb_m_if[g].sel;
    assign w_m_wdata[g] = wb_m_if[g].wdata;

    assign wb_m_if[g].rdata = wb_s_if.rdata;
    assign wb_m_if[g].ack   = r_grant[g] & wb_s_if.ack;
    assign wb_m_if[g].err   = r_grant[g] & (wb_s_if.err | w_tmo);
    assign wb_m_if[g].rty   = r_grant[g] & wb_s_if.rty;
    assign wb_m_if[g].stall = ~r_grant[g] | w_stall_g;
  end

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr (
    .i_req (w_m_cyc),
    .i_ptr (r_ptr),
    .o_gnt (w_win),
    .o_idx (w_win_idx)
  );

  assign w_gnt     = (r_state == GRANTED);
  assign w_full    = (r_outst == MAX_O);
  assign w_stall_g = wb_s_if.stall | w_full | w_tmo;
  assign w_resp    = w_gnt &
                     (wb_s_if.ack | wb_s_if.err | wb_s_if.rty);
  assign w_acc     = w_gnt & w_m_stb[r_idx] & ~w_stall_g;

  assign wb_s_if.cyc   = w_gnt & w_m_cyc[r_idx] & ~w_tmo;
  assign wb_s_if.stb   = w_gnt & w_m_stb[r_idx] &
                         ~w_full & ~w_tmo;
  assign wb_s_if.we    = w_gnt & w_m_we[r_idx];
  assign wb_s_if.lock  = w_gnt & w_m_lock[r_idx];
  assign wb_s_if.addr  = w_gnt ? w_m_addr[r_idx]  : '0;
  assign wb_s_if.sel   = w_gnt ? w_m_sel[r_idx]   : '0;
  assign wb_s_if.wdata = w_gnt ? w_m_wdata[r_idx] : '0;

  assign grant_o = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;
  logic          w_wd_run;

  assign w_wd_run = w_gnt & (r_outst != '0) & ~w_resp;
  assign w_tmo    = w_wd_run &
                    (r_wdog == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      r_wdog <= '0;
    else if (w_wd_run && !w_tmo)
      r_wdog <= r_wdog + 1'b1;
    else
      r_wdog <= '0;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_idx_nx   = r_idx;
    w_ptr_nx   = r_ptr;
    w_outst_nx = r_outst;
    unique case (r_state)
      IDLE: begin
        if (|w_m_cyc) begin
          w_state_nx = GRANTED;
          w_grant_nx = w_win;
          w_idx_nx   = w_win_idx;
          w_ptr_nx   = w_win_idx;
          w_outst_nx = '0;
        end
      end
      GRANTED: begin
        if (w_tmo)
          w_outst_nx = '0;
        else if (w_acc && !w_resp)
          w_outst_nx = r_outst + 1'b1;
        else if (!w_acc && w_resp && r_outst != '0)
          w_outst_nx = r_outst - 1'b1;
        // lock alone keeps the bus owned
        if (!w_m_cyc[r_idx] && !w_m_lock[r_idx]) begin
          w_state_nx = IDLE;
          w_grant_nx = '0;
          w_outst_nx = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= IW'(NUM_MASTERS - 1);
      r_outst <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_idx   <= w_idx_nx;
      r_ptr   <= w_ptr_nx;
      r_outst <= w_outst_nx;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (2 masters, cap 4).
// Define WB_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_wb_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rstn;

  logic [N-1:0] m_cyc, m_stb, m_we, m_lock;
  logic [31:0]  m_addr  [N];
  logic [N-1:0] m_ack, m_err, m_rty, m_stall;
  logic [31:0]  m_rdata [N];

  logic        s_cyc, s_stb, s_we, s_lock;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_stall;
  logic        man_ack;
  logic        slv_auto = 1'b0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic [31:0] slv_q [$];

  logic [N-1:0] grant_o;

  int vectors = 0;
  int miscompares = 0;

  wishbone_if m_if [N] ();
  wishbone_if s_if ();

  for (genvar g = 0; g < N; g++) begin : g_m
    assign m_if[g].cyc   = m_cyc[g];
    assign m_if[g].stb   = m_stb[g];
    assign m_if[g].we    = m_we[g];
    assign m_if[g].lock  = m_lock[g];
    assign m_if[g].addr  = m_addr[g];
    assign m_if[g].sel   = 4'hF;
    assign m_if[g].wdata = m_addr[g] ^ 32'h0000_1234;
    assign m_ack[g]   = m_if[g].ack;
    assign m_err[g]   = m_if[g].err;
    assign m_rty[g]   = m_if[g].rty;
    assign m_stall[g] = m_if[g].stall;
    assign m_rdata[g] = m_if[g].rdata;
  end

  assign s_if.rdata = slv_auto ? auto_rdata : 32'h0;
  assign s_if.ack   = slv_auto ? auto_ack : man_ack;
  assign s_if.err   = 1'b0;
  assign s_if.rty   = 1'b0;
  assign s_if.stall = s_stall;
  assign s_cyc   = s_if.cyc;
  assign s_stb   = s_if.stb;
  assign s_we    = s_if.we;
  assign s_lock  = s_if.lock;
  assign s_addr  = s_if.addr;
  assign s_sel   = s_if.sel;
  assign s_wdata = s_if.wdata;

  wb_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .wb_m_if (m_if),
    .wb_s_if (s_if),
    .grant_o (grant_o)
  );

  always #5 clk = ~clk;

  // Slave model: ack one cycle after each accepted strobe.
  always @(negedge clk)
    if (slv_auto && s_cyc && s_stb && !s_stall)
      slv_q.push_back(s_addr);

  always @(posedge clk) begin
    #2;
    if (slv_auto && slv_q.size() > 0) begin
      auto_ack   = 1'b1;
      auto_rdata = slv_q.pop_front() ^ 32'hA5A5_0000;
    end else begin
      auto_ack = 1'b0;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_cyc = '1; m_stb = '1; m_we = '0; m_lock = '0;
    m_addr[0] = 32'h10; m_addr[1] = 32'h20;
    s_stall = 1'b0; man_ack = 1'b0; slv_auto = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_grant got=%b want=00", grant_o);
    end
    vectors++;
    if ({s_cyc, s_stb, s_we, s_lock} !== 4'b0 ||
        s_addr !== 32'h0 || s_sel !== 4'h0 ||
        s_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_down got=%b%b%b%b %h %h %h want=0",
               s_cyc, s_stb, s_we, s_lock, s_addr, s_sel, s_wdata);
    end
    vectors++;
    if (m_stall !== 2'b11 || m_ack !== 2'b00 ||
        m_err !== 2'b00 || m_rty !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_masters stall=%b ack=%b err=%b rty=%b",
               m_stall, m_ack, m_err, m_rty);
    end
    vectors++;
    if (dut.r_outst !== '0) begin
      miscompares++;
      $display("FAIL reset_outst got=%0d want=0", dut.r_outst);
    end
    m_cyc = '0; m_stb = '0;
    next();
    rstn = 1'b1;
    next();
  endtask

  task automatic test_pipelined_reads();
    logic [31:0] eq [$];
    logic [31:0] ev;
    int sent, got;
    slv_auto = 1'b1;
    m_we[1] = 1'b0;
    m_cyc[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_latency grant=%b want=00", grant_o);
    end
    next();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL rd_grant grant=%b want=10", grant_o);
    end
    next();
    sent = 0; got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      m_stb[1]  = (sent < 3);
      m_addr[1] = 32'(32'h100 + sent * 4);
      @(negedge clk);
      vectors++;
      if (m_stall[0] !== 1'b1 || m_ack[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_m0_blocked stall=%b ack=%b want=1/0",
                 m_stall[0], m_ack[0]);
      end
      if (m_stb[1] && !m_stall[1]) begin
        eq.push_back(m_addr[1] ^ 32'hA5A5_0000);
        sent++;
      end
      if (m_ack[1]) begin
        got++;
        vectors++;
        if (eq.size() == 0) begin
          miscompares++;
          $display("FAIL rd_extra_ack got=ack want=none");
        end else begin
          ev = eq.pop_front();
          if (m_rdata[1] !== ev) begin
            miscompares++;
            $display("FAIL rd_data got=%h want=%h", m_rdata[1], ev);
          end
        end
      end
      next();
    end
    vectors++;
    if (got != 3 || sent != 3) begin
      miscompares++;
      $display("FAIL rd_count acks=%0d sent=%0d want=3/3", got, sent);
    end
    m_stb[1] = 1'b0;
    m_cyc[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL rd_hold grant=%b want=10", grant_o);
    end
    next();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_release grant=%b want=00", grant_o);
    end
    next();
  endtask

  task automatic test_round_robin();
    int gq [$];
    int skips [N];
    int ngr, widx, ev, gi;
    logic [N-1:0] prev, drop, restart, acc;
    slv_auto = 1'b1;
    gq.push_back(0); gq.push_back(1);
    gq.push_back(0); gq.push_back(1);
    for (int i = 0; i < N; i++) skips[i] = 0;
    prev = '0; drop = '0; restart = '0; ngr = 0;
    m_we = '1; m_addr[0] = 32'h200; m_addr[1] = 32'h300;
    m_cyc = '1; m_stb = '1;
    for (int c = 0; c < 80 && ngr < 4; c++) begin
      @(negedge clk);
      acc = '0;
      gi = grant_o[1] ? 1 : 0;
      vectors++;
      if (prev != '0 && grant_o != '0 && grant_o != prev) begin
        miscompares++;
        $display("FAIL rr_no_idle prev=%b now=%b", prev, grant_o);
      end
      if (grant_o != '0 && prev == '0) begin
        widx = gi;
        ngr++;
        vectors++;
        if (gq.size() == 0) begin
          miscompares++;
          $display("FAIL rr_order got=%0d want=none", widx);
        end else begin
          ev = gq.pop_front();
          if (widx != ev) begin
            miscompares++;
            $display("FAIL rr_order got=%0d want=%0d", widx, ev);
          end
        end
        for (int j = 0; j < N; j++)
          if (j == widx) skips[j] = 0;
          else skips[j]++;
        vectors++;
        if (skips[1 - widx] > N - 1) begin
          miscompares++;
          $display("FAIL rr_fair skips=%0d want<=%0d",
                   skips[1 - widx], N - 1);
        end
      end
      if (s_stb) begin
        vectors++;
        if (s_we !== 1'b1 ||
            s_wdata !== (m_addr[gi] ^ 32'h0000_1234)) begin
          miscompares++;
          $display("FAIL rr_wdata we=%b got=%h want=%h", s_we,
                   s_wdata, m_addr[gi] ^ 32'h0000_1234);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_stb[i] && !m_stall[i]) acc[i] = 1'b1;
        if (m_ack[i]) drop[i] = 1'b1;
      end
      prev = grant_o;
      next();
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
          drop[i] = 1'b0; restart[i] = 1'b1;
        end else if (restart[i]) begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
          restart[i] = 1'b0;
          m_addr[i] = m_addr[i] + 32'h10;
        end else if (acc[i]) begin
          m_stb[i] = 1'b0;
        end
      end
    end
    vectors++;
    if (ngr != 4) begin
      miscompares++;
      $display("FAIL rr_grants got=%0d want=4", ngr);
    end
    m_cyc = '0; m_stb = '0; m_we = '0;
    repeat (4) next();
    slv_auto = 1'b0;
    slv_q.delete();
  endtask

  task automatic test_outstanding_cap();
    int acc;
    slv_auto = 1'b0; man_ack = 1'b0; s_stall = 1'b0;
    m_we[0] = 1'b0; m_addr[0] = 32'h400;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    acc = 0;
    next();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (acc >= 4) begin
        vectors++;
        if (m_stall[0] !== 1'b1 || s_stb !== 1'b0) begin
          miscompares++;
          $display("FAIL cap_stall stall=%b s_stb=%b want=1/0",
                   m_stall[0], s_stb);
        end
      end
      if (m_stb[0] && !m_stall[0]) acc++;
      next();
      m_addr[0] = m_addr[0] + 32'h4;
    end
    vectors++;
    if (acc != 4 || dut.r_outst !== 3'd4) begin
      miscompares++;
      $display("FAIL cap_count acc=%0d outst=%0d want=4/4",
               acc, dut.r_outst);
    end
    man_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_stall[0] !== 1'b1 || m_ack[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL cap_ackcyc stall=%b ack=%b want=1/1",
               m_stall[0], m_ack[0]);
    end
    next();
    man_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_stall[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL cap_fifth stall=%b want=0", m_stall[0]);
    end
    next();
    @(negedge clk);
    vectors++;
    if (m_stall[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL cap_refull stall=%b want=1", m_stall[0]);
    end
    next();
    m_stb[0] = 1'b0; man_ack = 1'b1;
    next();
    next();
    m_stb[0] = 1'b1;
    vectors++;
    if (dut.r_outst !== 3'd2) begin
      miscompares++;
      $display("FAIL cap_drain outst=%0d want=2", dut.r_outst);
    end
    @(negedge clk);
    vectors++;
    if (m_stall[0] !== 1'b0 || m_ack[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL cap_both stall=%b ack=%b want=0/1",
               m_stall[0], m_ack[0]);
    end
    next();
    vectors++;
    if (dut.r_outst !== 3'd2) begin
      miscompares++;
      $display("FAIL cap_acc_ack outst=%0d want=2", dut.r_outst);
    end
    m_stb[0] = 1'b0;
    next();
    next();
    @(negedge clk);
    vectors++;
    if (m_ack[0] !== 1'b1 || dut.r_outst !== 3'd0) begin
      miscompares++;
      $display("FAIL cap_spurious ack=%b outst=%0d want=1/0",
               m_ack[0], dut.r_outst);
    end
    next();
    vectors++;
    if (dut.r_outst !== 3'd0) begin
      miscompares++;
      $display("FAIL cap_underflow outst=%0d want=0", dut.r_outst);
    end
    man_ack = 1'b0; m_cyc[0] = 1'b0;
    next();
    next();
  endtask

  task automatic test_lock();
    m_cyc[0] = 1'b1; m_lock[0] = 1'b1;
    next();
    m_cyc[0] = 1'b0; m_cyc[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (grant_o !== 2'b01 || s_lock !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_hold grant=%b lock=%b want=01/1",
                 grant_o, s_lock);
      end
      next();
    end
    m_lock[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_release grant=%b want=01", grant_o);
    end
    next();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL lock_idle grant=%b want=00", grant_o);
    end
    next();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_next grant=%b want=10", grant_o);
    end
    m_cyc[1] = 1'b0;
    next();
    next();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    bit seen, acc;
    slv_auto = 1'b0; man_ack = 1'b0;
    m_we[0] = 1'b0; m_addr[0] = 32'h800;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    acc = 0;
    for (int c = 0; c < 6 && !acc; c++) begin
      @(negedge clk);
      if (m_stb[0] && !m_stall[0]) acc = 1;
      next();
    end
    m_stb[0] = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL tmo_accept got=none want=1");
    end
    seen = 0; k = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (m_err[0]) begin
        seen = 1; k = c;
        vectors++;
        if (s_cyc !== 1'b0) begin
          miscompares++;
          $display("FAIL tmo_cyc s_cyc=%b want=0", s_cyc);
        end
      end
      next();
    end
    vectors++;
    if (k != 8) begin
      miscompares++;
      $display("FAIL tmo_time got=%0d want=8", k);
    end
    @(negedge clk);
    vectors++;
    if (m_err[0] !== 1'b0 || dut.r_outst !== 3'd0 ||
        grant_o !== 2'b01 || s_cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_after err=%b outst=%0d grant=%b cyc=%b",
               m_err[0], dut.r_outst, grant_o, s_cyc);
    end
    m_cyc[0] = 1'b0;
    next();
    next();
  endtask
`endif

  task automatic test_async_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 32'h900;
    next();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL ar_pre grant=%b want=10", grant_o);
    end
    next();
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if (grant_o !== 2'b00 || s_cyc !== 1'b0 ||
        s_stb !== 1'b0 || m_stall !== 2'b11 ||
        dut.r_outst !== 3'd0) begin
      miscompares++;
      $display("FAIL ar_now grant=%b cyc=%b stb=%b stall=%b outst=%0d",
               grant_o, s_cyc, s_stb, m_stall, dut.r_outst);
    end
    m_cyc = '0; m_stb = '0;
    next();
    rstn = 1'b1;
    next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pipelined_reads();
    test_round_robin();
    test_outstanding_cap();
    test_lock();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
